// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
package rr_arb_pkg;

  localparam int unsigned NumReq = 8;
  localparam int unsigned IdxW   = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StGap   = 2'd2
  } arb_state_e;

  // Binary index to one-hot, the inverse of the 8-to-3 encoder.
  function automatic logic [NumReq-1:0] onehot8(input logic [IdxW-1:0] idx);
    onehot8 = NumReq'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping 7 -> 0.
module rr_pick8
  import rr_arb_pkg::*;
(
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   ptr,
  output logic [IdxW-1:0]   pick_idx,
  output logic              any_req
);

  logic [NumReq-1:0] rot;
  logic [IdxW-1:0]   off;

  // Rotate right by ptr so bit 0 of rot is requester ptr; index arithmetic wraps mod 8.
  always_comb begin
    rot = '0;
    for (int i = 0; i < NumReq; i++) begin
      rot[i] = req[IdxW'(i) + ptr];
    end
  end

  // Lowest set bit of the rotated vector; scanning downward leaves the lowest one last.
  always_comb begin
    off = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (rot[i]) off = IdxW'(i);
    end
  end

  assign pick_idx = off + ptr;
  assign any_req  = |req;

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter, 8 requesters, registered one-hot and binary grant with hold timeout.
module rr_arbiter_8
  import rr_arb_pkg::*;
#(
  parameter int unsigned MaxHold = 16,
  parameter int unsigned CntW    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NumReq-1:0] req,
  input  logic              done,
  output logic [NumReq-1:0] gnt,
  output logic [IdxW-1:0]   gnt_idx,
  output logic              gnt_valid,
  output logic              timeout
);

  arb_state_e        state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [CntW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [NumReq-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0]   gnt_idx_q, gnt_idx_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic              timeout_q, timeout_d;

  logic [IdxW-1:0]   pick_idx;
  logic              any_req;
  logic              release_req;

  rr_pick8 u_pick (
    .req      (req),
    .ptr      (ptr_q),
    .pick_idx (pick_idx),
    .any_req  (any_req)
  );

  // Owner lets go explicitly or by withdrawing its request.
  assign release_req = done | ~req[gnt_idx_q];

  // Next-state and registered-output logic; everything holds unless a state acts on it.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          gnt_d       = onehot8(pick_idx);
          gnt_idx_d   = pick_idx;
          gnt_valid_d = 1'b1;
          ptr_d       = pick_idx + IdxW'(1);
          hold_cnt_d  = '0;
          state_d     = StGrant;
        end
      end
      StGrant: begin
        if (release_req || hold_cnt_q == CntW'(MaxHold - 1)) begin
          gnt_d       = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = '0;
          // A voluntary release in the last hold cycle is not a timeout.
          timeout_d   = ~release_req;
          state_d     = StGap;
        end else begin
          hold_cnt_d  = hold_cnt_q + CntW'(1);
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d     = StIdle;
        gnt_d       = '0;
        gnt_idx_d   = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
  a_idx_encodes : assert property (@(posedge clk) disable iff (!rst_n)
    gnt_q == (gnt_valid_q ? onehot8(gnt_idx_q) : NumReq'(0)) && (gnt_valid_q || gnt_idx_q == '0));
  a_valid_or    : assert property (@(posedge clk) disable iff (!rst_n) gnt_valid_q == |gnt_q);
  // A stray done with nothing granted must not move the FSM.
  a_done_idle   : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StIdle && done && req == '0) |=> state_q == StIdle);

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: vector table plus hand sequences for multi-cycle cases.
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] e_gnt;
    logic [2:0] e_idx;
    logic       e_valid;
    logic       e_to;
  } vec_t;

  vec_t tbl[$];

  rr_arbiter_8 #(
    .MaxHold (16),
    .CntW    (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic push(input logic r, input logic [7:0] q, input logic d,
                      input logic [7:0] eg, input logic [2:0] ei, input logic ev,
                      input logic et);
    vec_t v;
    v.rst_n = r; v.req = q; v.done = d;
    v.e_gnt = eg; v.e_idx = ei; v.e_valid = ev; v.e_to = et;
    tbl.push_back(v);
  endtask

  // Drive inputs mid-cycle, then sample just after the following rising edge.
  task automatic step(input logic r, input logic [7:0] q, input logic d);
    @(negedge clk);
    rst_n = r; req = q; done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [7:0] eg, input logic [2:0] ei,
                       input logic ev, input logic et);
    checks++;
    if (gnt !== eg || gnt_idx !== ei || gnt_valid !== ev || timeout !== et) begin
      failures++;
      $display("FAIL %s: got gnt=%h idx=%0d valid=%b timeout=%b, want gnt=%h idx=%0d valid=%b timeout=%b",
               nm, gnt, gnt_idx, gnt_valid, timeout, eg, ei, ev, et);
    end
  endtask

  task automatic sc(input string nm, input logic r, input logic [7:0] q, input logic d,
                    input logic [7:0] eg, input logic [2:0] ei, input logic ev,
                    input logic et);
    step(r, q, d);
    check(nm, eg, ei, ev, et);
  endtask

  initial begin
    logic [7:0] oh;
    logic [2:0] k3;

    rst_n = 1'b0; req = 8'h00; done = 1'b0;

    // Reset with everyone requesting, then rotation 0..7,0 with done on the 2nd grant cycle.
    push(1'b0, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    push(1'b0, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      k3 = 3'(k % 8);
      oh = 8'h01 << k3;
      push(1'b1, 8'hFF, 1'b0, oh,    k3,   1'b1, 1'b0); // issued from IDLE
      push(1'b1, 8'hFF, 1'b0, oh,    k3,   1'b1, 1'b0); // first GRANT cycle, held
      push(1'b1, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0); // done -> GAP
      push(1'b1, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0); // GAP -> IDLE
    end

    foreach (tbl[i]) begin
      step(tbl[i].rst_n, tbl[i].req, tbl[i].done);
      check($sformatf("vec%0d", i), tbl[i].e_gnt, tbl[i].e_idx, tbl[i].e_valid, tbl[i].e_to);
    end

    // Wrap and skip: ptr=1 now; grant 5 moves ptr to 6, then 05 wraps to 0, then skips to 2.
    sc("grant5",      1'b1, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);
    sc("rel5",        1'b1, 8'h20, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    sc("idle_a",      1'b1, 8'h05, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    sc("wrap_to_0",   1'b1, 8'h05, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
    sc("rel0",        1'b1, 8'h05, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    sc("idle_b",      1'b1, 8'h05, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    sc("skip_to_2",   1'b1, 8'h05, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
    sc("rel2",        1'b1, 8'h05, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    sc("idle_c",      1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    // Stray done with nothing granted is ignored.
    sc("stray_done",  1'b1, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);

    // Timeout: gnt=08 for exactly 16 cycles, one timeout cycle, then re-grant to 3.
    for (int c = 0; c < 16; c++) begin
      sc($sformatf("hold%0d", c), 1'b1, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
    end
    sc("timeout",     1'b1, 8'h08, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
    sc("to_idle",     1'b1, 8'h08, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    sc("regrant3",    1'b1, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);

    // Withdraw in the hold_cnt=15 cycle: release wins, no timeout.
    for (int c = 1; c < 16; c++) begin
      sc($sformatf("chold%0d", c), 1'b1, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
    end
    sc("collide",     1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    sc("coll_idle",   1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

    // Mid-grant reset: ptr=4, grant 5, reset drops it at once and restarts ptr at 0.
    sc("grant5b",     1'b1, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);
    sc("mid_reset",   1'b0, 8'h21, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    sc("post_rst0",   1'b1, 8'h21, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
    sc("post_rel",    1'b1, 8'h21, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    sc("post_idle",   1'b1, 8'h21, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    sc("post_rst5",   1'b1, 8'h21, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Round-robin arbiter that shares one 8-slot resource between 8 requesters.
- Returns each grant two ways: a one-hot vector, and the equivalent 3-bit binary index (the same encoding the 8-to-3 encoder produces).
- Downstream muxes select on the binary index; requesters watch their one-hot bit.
- Each grant is held until the owner releases it or a hold timeout fires.

Parameters:
- N, 8, number of requesters (fixed at 8 for this block).
- IDXW, 3, index width, log2(N).
- MAX_HOLD, 16, maximum cycles one grant may be held (legal range 2..255).
- CNTW, 8, width of the hold counter; must satisfy MAX_HOLD <= 2^CNTW - 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low, sampled on the clk rising edge.
- req  input  8  request vector; bit i = requester i.
- done  input  1  release pulse from the current owner.
- gnt  output  8  registered one-hot grant; all zeros when idle.
- gnt_idx  output  3  registered binary index of the owner; 3'b000 when idle.
- gnt_valid  output  1  high while any grant is held; equals the OR of gnt.
- timeout  output  1  one-cycle pulse when a grant is force-released.

Behaviour:
- One clock, clk. Reset is synchronous and active-low: rst_n is sampled on the rising edge of clk, and all state is cleared on an edge where rst_n=0.
- Reset values: gnt=8'h00, gnt_idx=3'b000, gnt_valid=0, timeout=0, state=IDLE, ptr=3'd0, hold_cnt=0.
- Reset mid-grant drops gnt at that same edge; no timeout pulse is produced.
- All outputs come straight from registers; there is no combinational path from input to output.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If req != 0, pick the first set bit scanning upward from ptr, wrapping 7 -> 0.
  - At the next edge: gnt = one-hot(pick), gnt_idx = pick, ptr = (pick+1) mod 8, hold_cnt = 0, go to GRANT.
  - Latency: req seen in cycle t gives gnt high in cycle t+1.
  - If req == 0, stay in IDLE.
- GRANT:
  - Release occurs on either of: done=1, or req[gnt_idx]=0 (owner withdrew).
  - On release: clear gnt/gnt_valid at the next edge and go to GAP.
  - Otherwise, if hold_cnt == MAX_HOLD-1: force-release, set timeout=1 for exactly one cycle (the GAP cycle), go to GAP.
  - Otherwise hold_cnt increments.
  - If a release and the timeout happen in the same cycle, release wins and timeout stays 0.
- GAP:
  - Exactly one dead cycle with gnt=0, used for bus turnaround.
  - Then unconditionally go to IDLE.
  - Arbitration in the IDLE cycle uses the updated ptr.
- Fairness:
  - ptr advances only when a grant is issued.
  - With all 8 requesting continuously, grants rotate 0,1,...,7,0.
  - Worst-case wait is 7 × (MAX_HOLD + 2) cycles.
- Assertion: done while gnt_valid=0 is ignored.
- Assertion: gnt is always one-hot or zero.
- Assertion: gnt_idx always encodes gnt.

Decomposition:
- Package rr_arb_pkg holds:
  - the state enum {IDLE, GRANT, GAP} (2-bit);
  - constants N=8, IDXW=3;
  - a function onehot8(idx) returning 8-bit one-hot.
- Sub-module rr_pick8 (purely combinational):
  - inputs req[7:0] and ptr[2:0];
  - outputs pick_idx[2:0] and any_req;
  - implementation: rotate req right by ptr, take the lowest set bit, add ptr mod 8.
- The top level holds the FSM, ptr, hold_cnt and the output registers.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with req=8'hFF -> gnt=00, gnt_idx=0, timeout=0. After release, first gnt=8'h01 one cycle later.
- Rotation: req=8'hFF held, done pulsed on every 2nd GRANT cycle -> gnt_idx sequence 0,1,2,...,7,0. Each grant is separated by exactly one GAP cycle with gnt=00.
- Wrap and skip: ptr=6 (after granting 5), req=8'b0000_0101 -> gnt_idx=0 next. Then with req still 8'b0000_0101, after release -> gnt_idx=2.
- Timeout: MAX_HOLD=16, req=8'h08 held, done=0 -> gnt=8'h08 for exactly 16 cycles, then timeout=1 for 1 cycle with gnt=00. Re-grant to 3 in the following cycle.
- Withdraw vs. timeout collision: req[3] drops in the same cycle hold_cnt=15 -> release taken, timeout stays 0.
- Mid-grant reset: rst_n=0 while gnt=8'h20 -> gnt=00 at that edge, ptr=0. With req=8'h21 after reset, the next grant is idx 0.
